// File: rtl/tl_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tl_request_scheduler
// Purpose  : Sensor front end for the four-approach traffic light controller.
//            Debounces presence sensors, holds requests until served, ages
//            outstanding requests, masks to a single starving approach, and
//            predicts the next approach to receive green.
// Revision : 1.0 - initial release
// ============================================================================
module tl_request_scheduler #(
  parameter int DEB_CYCLES   = 4,
  parameter int AGE_W        = 8,
  parameter int STARVE_LIMIT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_ss,
  input  logic [3:0] raw_fs,
  input  logic [3:0] green,
  input  logic [3:0] yellow,
  output logic [3:0] ss,
  output logic [3:0] fs,
  output logic [3:0] starve,
  output logic [3:0] next_grant
);

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_DEB      = 2'd1;
  localparam logic [1:0]       c_PEND     = 2'd2;
  localparam logic [1:0]       c_SERVE    = 2'd3;
  localparam logic [3:0]       c_DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [AGE_W-1:0] c_AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] c_STARVE   = AGE_W'(STARVE_LIMIT);

  logic [3:0]            w_pend;
  logic [3:0]            w_starve;
  logic [3:0]            w_fs_lat;
  logic [3:0][AGE_W-1:0] w_age;

  genvar lane;
  generate
    for (lane = 0; lane < 4; lane++) begin : g_lane
      logic [1:0]       r_state;
      logic [1:0]       w_state_nxt;
      logic [3:0]       r_deb_cnt;
      logic [3:0]       w_deb_nxt;
      logic             r_fs_lat;
      logic             w_fs_nxt;
      logic [AGE_W-1:0] r_age;
      logic [AGE_W-1:0] w_age_nxt;

      // Lane state, debounce count, bonus latch and age register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state   <= c_IDLE;
          r_deb_cnt <= 4'd0;
          r_fs_lat  <= 1'b0;
          r_age     <= '0;
        end else begin
          r_state   <= w_state_nxt;
          r_deb_cnt <= w_deb_nxt;
          r_fs_lat  <= w_fs_nxt;
          r_age     <= w_age_nxt;
        end
      end

      // Next-state logic; fs latch and age only survive while staying in PEND.
      always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_fs_nxt    = 1'b0;
        w_age_nxt   = '0;
        case (r_state)
          c_IDLE: begin
            if (raw_ss[lane]) begin
              if (DEB_CYCLES == 1) begin
                w_state_nxt = c_PEND;
              end else begin
                w_state_nxt = c_DEB;
                w_deb_nxt   = 4'd1;
              end
            end
          end
          c_DEB: begin
            if (raw_ss[lane]) begin
              if (r_deb_cnt >= c_DEB_LAST) begin
                w_state_nxt = c_PEND;
                w_deb_nxt   = 4'd0;
              end else begin
                w_deb_nxt   = r_deb_cnt + 4'd1;
              end
            end else begin
              w_state_nxt = c_IDLE;
              w_deb_nxt   = 4'd0;
            end
          end
          c_PEND: begin
            if (green[lane]) begin
              w_state_nxt = c_SERVE;
            end else begin
              w_fs_nxt  = r_fs_lat | raw_fs[lane];
              w_age_nxt = (r_age == c_AGE_MAX) ? r_age : r_age + 1'b1;
            end
          end
          default: begin
            if (!green[lane]) begin
              w_state_nxt = c_IDLE;
            end
          end
        endcase
      end

      // Per-lane outputs decoded purely from registered state.
      assign w_pend[lane]   = (r_state == c_PEND);
      assign w_starve[lane] = w_pend[lane] && (r_age >= c_STARVE);
      assign w_fs_lat[lane] = r_fs_lat;
      assign w_age[lane]    = r_age;
    end
  endgenerate

  logic             w_any_starve;
  logic [1:0]       w_best_idx;
  logic [AGE_W-1:0] w_best_age;
  logic             w_best_found;
  logic [3:0]       w_ss;

  // Mask requests to the oldest starving lane (lowest index wins ties).
  always_comb begin
    w_any_starve = |w_starve;
    w_best_idx   = 2'd0;
    w_best_age   = '0;
    w_best_found = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (w_starve[j] && (!w_best_found || (w_age[j] > w_best_age))) begin
        w_best_found = 1'b1;
        w_best_idx   = 2'(j);
        w_best_age   = w_age[j];
      end
    end
    w_ss = w_any_starve ? (4'b0001 << w_best_idx) : w_pend;
  end

  logic [1:0] w_ref;
  logic [1:0] w_idx;
  logic       w_ng_found;
  logic [3:0] w_next_grant;

  // Round-robin prediction starting after the lane currently holding the lamp.
  always_comb begin
    w_ref        = 2'd3;
    w_idx        = 2'd0;
    w_ng_found   = 1'b0;
    w_next_grant = 4'b0000;
    if (|green) begin
      for (int j = 3; j >= 0; j--) begin
        if (green[j]) w_ref = 2'(j);
      end
    end else if (|yellow) begin
      for (int j = 3; j >= 0; j--) begin
        if (yellow[j]) w_ref = 2'(j);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      w_idx = w_ref + 2'(k);
      if (!w_ng_found && w_ss[w_idx]) begin
        w_ng_found   = 1'b1;
        w_next_grant = 4'b0001 << w_idx;
      end
    end
  end

  assign ss         = w_ss;
  assign fs         = w_fs_lat & w_ss;
  assign starve     = w_starve;
  assign next_grant = w_next_grant;

endmodule
`default_nettype wire

// File: tb/tb_tl_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_request_scheduler
// Purpose  : Directed self-checking bench for tl_request_scheduler
//            (DEB_CYCLES=4, STARVE_LIMIT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_request_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw_ss;
  logic [3:0] raw_fs;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] ss;
  logic [3:0] fs;
  logic [3:0] starve;
  logic [3:0] next_grant;

  int total = 0;
  int bad   = 0;

  tl_request_scheduler #(
    .DEB_CYCLES  (4),
    .AGE_W       (8),
    .STARVE_LIMIT(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_ss    (raw_ss),
    .raw_fs    (raw_fs),
    .green     (green),
    .yellow    (yellow),
    .ss        (ss),
    .fs        (fs),
    .starve    (starve),
    .next_grant(next_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    raw_ss = 4'b0000;
    raw_fs = 4'b0000;
    green  = 4'b0000;
    yellow = 4'b0000;
    repeat (2) tick();
    chk("rst_ss", ss, 4'b0000);
    chk("rst_fs", fs, 4'b0000);
    chk("rst_starve", starve, 4'b0000);
    chk("rst_ng", next_grant, 4'b0000);

    // Lane 2 debounce: four high samples latch the request.
    rst_n  = 1'b1;
    green  = 4'b0001;
    raw_ss = 4'b0100;
    repeat (3) tick();
    chk("deb_3_edges", ss, 4'b0000);
    tick();
    chk("deb_4_edges", ss, 4'b0100);
    chk("deb_ng", next_grant, 4'b0100);
    raw_ss = 4'b0000;

    // Lane 1 glitch of three cycles never latches.
    raw_ss = 4'b0010;
    repeat (3) tick();
    chk("glitch_3", ss, 4'b0100);
    raw_ss = 4'b0000;
    tick();
    chk("glitch_drop", ss, 4'b0100);

    // Bonus flag captured in PEND and held after sensors drop.
    raw_fs = 4'b0100;
    tick();
    raw_fs = 4'b0000;
    chk("fs_set", fs, 4'b0100);
    chk("fs_ss", ss, 4'b0100);
    tick();
    chk("fs_hold", fs, 4'b0100);
    green = 4'b0100;
    tick();
    chk("serve_ss", ss, 4'b0000);
    chk("serve_fs", fs, 4'b0000);
    green = 4'b0000;
    tick();
    chk("idle_ss", ss, 4'b0000);
    chk("idle_ng", next_grant, 4'b0000);

    // Lane 3 latches, then lane 0 latches five cycles later.
    raw_ss = 4'b1000;
    repeat (4) tick();
    chk("l3_latch", ss, 4'b1000);
    raw_ss = 4'b0000;
    tick();
    raw_ss = 4'b0001;
    repeat (4) tick();
    raw_ss = 4'b0000;
    chk("both_ss", ss, 4'b1001);
    chk("both_ng_r3", next_grant, 4'b0001);

    // Prediction from green / yellow reference, including wrap-around.
    green = 4'b0010;
    #1;
    chk("ng_green1", next_grant, 4'b1000);
    green = 4'b1000;
    #1;
    chk("ng_green3_wrap", next_grant, 4'b0001);
    green  = 4'b0000;
    yellow = 4'b0001;
    #1;
    chk("ng_yellow0", next_grant, 4'b1000);
    yellow = 4'b0000;

    // Lane 3 age 9: not yet starving.
    repeat (4) tick();
    chk("age9_starve", starve, 4'b0000);
    chk("age9_ss", ss, 4'b1001);
    // Lane 3 age 10: starving, request vector masked.
    tick();
    chk("starve3", starve, 4'b1000);
    chk("starve3_ss", ss, 4'b1000);
    chk("starve3_ng", next_grant, 4'b1000);
    repeat (4) tick();
    chk("lane0_age9", starve, 4'b1000);
    tick();
    chk("both_starve", starve, 4'b1001);
    chk("both_starve_ss", ss, 4'b1000);

    // Third lane pending behind the mask.
    raw_ss = 4'b0010;
    repeat (4) tick();
    raw_ss = 4'b0000;
    chk("three_starve", starve, 4'b1001);
    chk("three_ss", ss, 4'b1000);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ss", ss, 4'b0000);
    chk("async_fs", fs, 4'b0000);
    chk("async_starve", starve, 4'b0000);
    chk("async_ng", next_grant, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ss", ss, 4'b0000);
    chk("post_rst_starve", starve, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
